// File: rtl/return_stack_if.sv
// Request/response bundle between the stack control logic and the return-address stack.
// The requester drives push/pop/err_clr; the stack reports its status and popped entries.
interface return_stack_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] push_data;
  logic              err_clr;
  logic              ready;
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, pop, push_data, err_clr,
    input  ready, pop_data, pop_valid, count, full, empty, overflow, underflow
  );

  modport slave (
    input  push, pop, push_data, err_clr,
    output ready, pop_data, pop_valid, count, full, empty, overflow, underflow
  );
endinterface

// File: rtl/return_stack.sv
// Return-address stack with its own pointer, occupancy count and sticky fault flags.
// Optional macro RETURN_STACK_CIRCULAR_EN: push while full overwrites the oldest entry instead of faulting.
module return_stack #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  return_stack_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESP  = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W+1)'(DEPTH);

  state_t            state, state_next;
  logic [ADDR_W-1:0] sp, sp_next, top;
  logic [ADDR_W:0]   count, count_next;
  logic [DATA_W-1:0] pop_data;
  logic              overflow, underflow;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_en;
  logic              set_ovf, set_unf, clr_err;
  logic              is_full, is_empty;

  // Top of stack is the slot just below the next free one, wrapping modulo DEPTH.
  assign top      = sp - ADDR_W'(1);
  assign is_full  = (count == COUNT_FULL);
  assign is_empty = (count == '0);

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_next = state;
    sp_next    = sp;
    count_next = count;
    wr_en      = 1'b0;
    wr_addr    = sp;
    rd_en      = 1'b0;
    set_ovf    = 1'b0;
    set_unf    = 1'b0;
    clr_err    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.push && bus.pop && !is_empty) begin
          // Replace top: old entry goes out, new one takes its slot.
          rd_en      = 1'b1;
          wr_en      = 1'b1;
          wr_addr    = top;
          state_next = RESP;
        end else if (bus.push) begin
          if (!is_full) begin
            wr_en      = 1'b1;
            sp_next    = sp + ADDR_W'(1);
            count_next = count + (ADDR_W+1)'(1);
          end else begin
            set_ovf = 1'b1;
`ifdef RETURN_STACK_CIRCULAR_EN
            wr_en   = 1'b1;
            sp_next = sp + ADDR_W'(1);
`else
            state_next = FAULT;
`endif
          end
        end else if (bus.pop) begin
          if (!is_empty) begin
            rd_en      = 1'b1;
            sp_next    = top;
            count_next = count - (ADDR_W+1)'(1);
            state_next = RESP;
          end else begin
            set_unf    = 1'b1;
            state_next = FAULT;
          end
        end
      end
      RESP: state_next = IDLE;
      FAULT: begin
        if (bus.err_clr) begin
          clr_err    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: non-blocking updates let the replace case read the old mem[top] on the same edge it is overwritten.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sp        <= '0;
      count     <= '0;
      pop_data  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state <= state_next;
      sp    <= sp_next;
      count <= count_next;
      if (rd_en) begin
        pop_data <= mem[top];
      end
      if (clr_err) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (set_ovf) overflow  <= 1'b1;
        if (set_unf) underflow <= 1'b1;
      end
    end
  end

  // NOTE: storage is deliberately left out of reset; entries are only meaningful below sp.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= bus.push_data;
    end
  end

  assign bus.ready     = (state == IDLE);
  assign bus.pop_valid = (state == RESP);
  assign bus.pop_data  = pop_data;
  assign bus.count     = count;
  assign bus.full      = is_full;
  assign bus.empty     = is_empty;
  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;

endmodule

// File: tb/tb_return_stack.sv
// Scoreboard bench for return_stack: pops queue their expected entry and response cycle,
// a negedge monitor retires them whenever pop_valid is seen.
module tb_return_stack;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  return_stack_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  return_stack #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pop_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.pop_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop_valid: got pop_data 0x%0h with no pop outstanding (cycle %0d)",
                 bus.pop_data, cyc);
      end else begin
        e = sb.pop_front();
        check("pop_data", 64'(bus.pop_data), 64'(e.data));
        check("pop_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("ready_wait", 64'(bus.ready), 64'(1));
  endtask

  task automatic do_push(input logic [DATA_W-1:0] d);
    wait_ready();
    bus.push      = 1'b1;
    bus.push_data = d;
    step();
    bus.push      = 1'b0;
  endtask

  task automatic do_pop(input logic [DATA_W-1:0] exp_d);
    wait_ready();
    bus.pop = 1'b1;
    sb.push_back('{exp_d, cyc + 1});
    step();
    bus.pop = 1'b0;
  endtask

  task automatic do_replace(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp_d);
    wait_ready();
    bus.push      = 1'b1;
    bus.pop       = 1'b1;
    bus.push_data = d;
    sb.push_back('{exp_d, cyc + 1});
    step();
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.push_data = '0;
    bus.err_clr   = 1'b0;

    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",     64'(bus.ready),     64'(1));
    check("rst_empty",     64'(bus.empty),     64'(1));
    check("rst_full",      64'(bus.full),      64'(0));
    check("rst_count",     64'(bus.count),     64'(0));
    check("rst_pop_valid", 64'(bus.pop_valid), 64'(0));
    check("rst_overflow",  64'(bus.overflow),  64'(0));
    check("rst_underflow", 64'(bus.underflow), 64'(0));
    reset = 1'b0;
    step();

    // Back-to-back pushes
    do_push(32'h10); check("b2b_ready1", 64'(bus.ready), 64'(1));
    do_push(32'h20); check("b2b_ready2", 64'(bus.ready), 64'(1));
    do_push(32'h30); check("b2b_ready3", 64'(bus.ready), 64'(1));
    check("count_3", 64'(bus.count), 64'(3));
    check("empty_0", 64'(bus.empty), 64'(0));

    // LIFO pops
    do_pop(32'h30);
    do_pop(32'h20);
    do_pop(32'h10);
    step();
    check("count_0",        64'(bus.count),     64'(0));
    check("empty_1",        64'(bus.empty),     64'(1));
    check("pop_valid_low",  64'(bus.pop_valid), 64'(0));
    check("pop_data_holds", 64'(bus.pop_data),  64'(32'h10));

    // Replace top
    do_push(32'hA);
    do_replace(32'hB, 32'hA);
    check("replace_count", 64'(bus.count), 64'(1));
    do_pop(32'hB);
    step();
    check("replace_empty", 64'(bus.empty), 64'(1));

    // Fill to DEPTH, then push while full
    for (int i = 0; i < DEPTH; i++) do_push(DATA_W'(i));
    check("full_1",     64'(bus.full),  64'(1));
    check("full_count", 64'(bus.count), 64'(DEPTH));
    do_push(32'h99);
`ifdef RETURN_STACK_CIRCULAR_EN
    check("circ_overflow", 64'(bus.overflow), 64'(1));
    check("circ_ready",    64'(bus.ready),    64'(1));
    check("circ_count",    64'(bus.count),    64'(DEPTH));
    do_pop(32'h99);
    for (int i = DEPTH - 1; i >= 1; i--) do_pop(DATA_W'(i));
`else
    check("ovf_overflow", 64'(bus.overflow), 64'(1));
    check("ovf_ready",    64'(bus.ready),    64'(0));
    check("ovf_count",    64'(bus.count),    64'(DEPTH));
    step();
    check("ovf_held",     64'(bus.ready),    64'(0));
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    check("ovf_clr_ready",    64'(bus.ready),    64'(1));
    check("ovf_clr_overflow", 64'(bus.overflow), 64'(0));
    for (int i = DEPTH - 1; i >= 0; i--) do_pop(DATA_W'(i));
`endif
    step();
    check("drain_count", 64'(bus.count), 64'(0));

    // Pop while empty -> FAULT
    wait_ready();
    bus.pop = 1'b1;
    step();
    bus.pop = 1'b0;
    check("unf_underflow", 64'(bus.underflow), 64'(1));
    check("unf_ready",     64'(bus.ready),     64'(0));
    check("unf_pop_valid", 64'(bus.pop_valid), 64'(0));
    bus.push      = 1'b1;
    bus.push_data = 32'h77;
    repeat (3) step();
    bus.push      = 1'b0;
    check("unf_push_ignored", 64'(bus.count), 64'(0));
    check("unf_still_fault",  64'(bus.ready), 64'(0));
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    check("unf_clr_ready",     64'(bus.ready),     64'(1));
    check("unf_clr_underflow", 64'(bus.underflow), 64'(0));
    check("unf_clr_overflow",  64'(bus.overflow),  64'(0));
    do_push(32'h5);
    do_pop(32'h5);
    step();

    // Asynchronous reset in the middle of a response cycle
    do_push(32'h1);
    do_push(32'h2);
    wait_ready();
    bus.pop = 1'b1;
    step();
    bus.pop = 1'b0;
    check("resp_before_reset", 64'(bus.pop_valid), 64'(1));
    reset = 1'b1;
    #1;
    check("async_pop_valid", 64'(bus.pop_valid), 64'(0));
    check("async_count",     64'(bus.count),     64'(0));
    check("async_empty",     64'(bus.empty),     64'(1));
    check("async_ready",     64'(bus.ready),     64'(1));
    check("async_pop_data",  64'(bus.pop_data),  64'(0));
    step();
    reset = 1'b0;
    repeat (2) step();

    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/return_stack.md
Name: return_stack

Overview:
- Return-address stack storage that services the push/pop requests produced by the stack control logic.
- On push it stores the return address, typically PC+1 at JAL. On pop it returns the top entry to the PC-select path at function end.
- Maintains its own stack pointer, full/empty status and fault state. Sits between control and the PC mux in the multi-cycle datapath.

Parameters:
- DEPTH, 16, number of 32-bit entries; power of two, minimum 4.
- ADDR_W, 4, log2(DEPTH).
- DATA_W, 32, entry width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- push  input  1  push request; sampled only when ready=1.
- pop  input  1  pop request; sampled only when ready=1.
- push_data  input  DATA_W  return address to store.
- err_clr  input  1  leaves FAULT state.
- ready  output  1  block accepts a request this cycle.
- pop_data  output  DATA_W  popped entry; valid only while pop_valid=1.
- pop_valid  output  1  one-cycle pulse, one cycle after an accepted pop.
- count  output  ADDR_W+1  current number of stored entries (0..DEPTH).
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- overflow  output  1  sticky; push attempted while full.
- underflow  output  1  sticky; pop attempted while empty.

Behaviour:
- Reset (async, any state): state=IDLE, sp=0, count=0, pop_data=0, pop_valid=0, overflow=0, underflow=0. Outputs ready=1, empty=1, full=0. Memory contents are not cleared.
- Storage: mem[0..DEPTH-1]. sp points to the next free slot. The top entry is mem[sp-1], computed modulo DEPTH.
- States:
  - IDLE: ready=1.
  - RESP: ready=0; pop_valid=1 for exactly this one cycle.
  - FAULT: ready=0; no push or pop is accepted.
- IDLE, push only, not full: mem[sp]<=push_data; sp<=sp+1; count+1. Next state IDLE, so pushes are back-to-back capable.
- IDLE, pop only, not empty: pop_data<=mem[sp-1]; sp<=sp-1; count-1. Next state RESP, so pop_data/pop_valid appear one cycle after the request.
- IDLE, push and pop together, count>=1 (replace top):
  - pop_data<=old mem[sp-1], then mem[sp-1]<=push_data.
  - sp and count unchanged. Next state RESP.
- IDLE, push and pop together, empty: treated as push only, and the pop is dropped. underflow is not set.
- IDLE, push while full: no write, sp unchanged. overflow<=1, next state FAULT.
- IDLE, pop while empty: sp unchanged. underflow<=1, next state FAULT. pop_valid is not asserted.
- RESP always returns to IDLE the next cycle. Requests presented during RESP are ignored (ready=0); the requester must hold them.
- FAULT stays until err_clr=1, then goes to IDLE and clears overflow and underflow. Stack contents and sp are preserved.
- err_clr outside FAULT has no effect.
- sp arithmetic is ADDR_W bits and wraps modulo DEPTH. count saturates only through the full/empty checks above.
- pop_data holds its last value when pop_valid=0.

Optional Feature:
- Macro: RETURN_STACK_CIRCULAR_EN.
- Defined:
  - Push while full does not fault. mem[sp]<=push_data overwrites the oldest entry, sp<=sp+1, count stays DEPTH.
  - overflow is set as a sticky warning, but state remains IDLE.
  - Pop while empty still faults.
- Undefined: push while full enters FAULT, as specified in Behaviour.

Test Plan:
- Reset, then push 0x00000010, 0x00000020, 0x00000030 on consecutive cycles -> count=3; ready stays 1; empty=0.
- Then pop three times, each waiting for ready -> pop_valid pulses with pop_data 0x30, 0x20, 0x10, each one cycle after its request; finally count=0, empty=1.
- Push 0xA, then push=pop=1 with push_data 0xB -> next cycle pop_valid=1, pop_data=0xA, count=1. A following pop returns 0xB.
- Push DEPTH entries 0..15 (full=1), then push 0x99:
  - Without macro: overflow=1, ready=0, count=16. err_clr returns the block to IDLE; popping returns 15.
  - With macro: no fault, count=16; popping returns 0x99, then 15..1.
- Pop on empty -> underflow=1, FAULT, no pop_valid. Push is ignored until err_clr. After clear, push 0x5 then pop returns 0x5.
- Assert reset mid-RESP after 2 pushes and a pop -> pop_valid=0, count=0, empty=1, ready=1 immediately (asynchronous).
